// File: rtl/fp_conv_pkg.sv
// Shared definitions for the fixed-point <-> IEEE-754 single converters.
package fp_conv_pkg;

    localparam int FP_BIAS   = 127;
    localparam int FP_MANT_W = 23;
    localparam int FP_EXP_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_NORM,
        S_ROUND,
        S_DONE
    } conv_state_t;

endpackage

// File: rtl/fp_round_ne.sv
// Exponent/mantissa extraction from a normalized magnitude, round-to-nearest-even.
module fp_round_ne
    import fp_conv_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic [31:0]          mag,
    input  logic [4:0]           sc,
    output logic [FP_EXP_W-1:0]  exp,
    output logic [FP_MANT_W-1:0] mant
);

    logic                 lsb;
    logic                 guard;
    logic                 sticky;
    logic                 inc;
    logic [FP_MANT_W:0]   mant_sum;
    logic [8:0]           exp_base;
    logic [8:0]           exp_full;
    logic                 unused_bits;

    always_comb begin
        lsb      = mag[8];
        guard    = mag[7];
        sticky   = |mag[6:0];
        inc      = guard && (sticky || lsb);
        // Carry out of the 23-bit field leaves zeros below it and bumps the exponent.
        mant_sum = {1'b0, mag[30:8]} + {{FP_MANT_W{1'b0}}, inc};
        exp_base = 9'(FP_BIAS + 31 - FRAC_BITS) - {4'b0000, sc};
        exp_full = exp_base + {8'd0, mant_sum[FP_MANT_W]};
        exp      = exp_full[FP_EXP_W-1:0];
        mant     = mant_sum[FP_MANT_W-1:0];
    end

    // Hidden bit and the 9th exponent bit are never needed.
    assign unused_bits = &{1'b0, mag[31], exp_full[8]};

endmodule

// File: rtl/fixed_to_fp.sv
// Iterative signed Q(32-FRAC_BITS).FRAC_BITS to IEEE-754 single converter, ready/valid on both sides.
module fixed_to_fp
    import fp_conv_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    generate
        if (FRAC_BITS < 0 || FRAC_BITS > 31) begin : g_bad_frac
            $error("fixed_to_fp: FRAC_BITS must lie in 0..31");
        end
    endgenerate

    conv_state_t             state;
    conv_state_t             state_next;
    logic [31:0]             data_q;
    logic [31:0]             mag;
    logic [31:0]             abs_mag;
    logic [4:0]              sc;
    logic                    sign;
    logic [FP_EXP_W-1:0]     r_exp;
    logic [FP_MANT_W-1:0]    r_mant;

    fp_round_ne #(
        .FRAC_BITS(FRAC_BITS)
    ) u_round (
        .mag  (mag),
        .sc   (sc),
        .exp  (r_exp),
        .mant (r_mant)
    );

    assign abs_mag = data_q[31] ? (~data_q + 32'd1) : data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Normalization looks one bit ahead so a magnitude with lz leading zeros
    // spends exactly lz cycles shifting (none when the MSB is already set).
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_ABS;
            end
            S_ABS: begin
                if (abs_mag == '0)     state_next = S_DONE;
                else if (abs_mag[31])  state_next = S_ROUND;
                else                   state_next = S_NORM;
            end
            S_NORM: begin
                if (mag[30]) state_next = S_ROUND;
            end
            S_ROUND: state_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            mag      <= '0;
            sc       <= '0;
            sign     <= 1'b0;
            out_data <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) data_q <= in_data;
                end
                S_ABS: begin
                    sign <= data_q[31];
                    mag  <= abs_mag;
                    sc   <= '0;
                    if (abs_mag == '0) out_data <= '0;
                end
                S_NORM: begin
                    mag <= {mag[30:0], 1'b0};
                    sc  <= sc + 5'd1;
                end
                S_ROUND: out_data <= {sign, r_exp, r_mant};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_to_fp.sv
// Scoreboarded random/directed bench for fixed_to_fp against an arithmetic reference model.
module tb_fixed_to_fp;

    localparam int FRAC = 16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    fixed_to_fp #(
        .FRAC_BITS(FRAC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    typedef struct {
        logic [31:0] val;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   rand_ready = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: value = x / 2^FRAC, rounded to nearest-even at 24 significant bits.
    function automatic logic [31:0] ref_fp(input logic [31:0] x);
        longint m, mag, rem, half;
        int     p, e, sh;
        logic [31:0] r;
        if (x == 32'd0) return 32'd0;
        mag = longint'($signed(x));
        if (mag < 0) mag = -mag;
        p = 63;
        while (mag[p] == 1'b0) p--;
        e = p - FRAC + 127;
        if (p > 23) begin
            sh   = p - 23;
            m    = mag >> sh;
            rem  = mag - (m << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && m[0])) m++;
            if (m == (longint'(1) << 24)) begin
                m = m >> 1;
                e++;
            end
        end else begin
            m = mag << (23 - p);
        end
        r = {x[31], e[7:0], m[22:0]};
        return r;
    endfunction

    function automatic int ref_lat(input logic [31:0] x);
        longint mag;
        int p;
        if (x == 32'd0) return 2;
        mag = longint'($signed(x));
        if (mag < 0) mag = -mag;
        p = 31;
        while (mag[p] == 1'b0) p--;
        return (31 - p) + 3;
    endfunction

    task automatic send(input logic [31:0] d, input logic [31:0] want, input int lat);
        exp_t e;
        int unsigned guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 500) begin
                in_valid = 1'b0;
                chk("in_ready_timeout", 32'd0, 32'd1);
                return;
            end
        end
        e.val = want;
        e.lat = lat;
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [31:0] d);
        send(d, ref_fp(d), ref_lat(d));
    endtask

    task automatic drain();
        int unsigned guard = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                chk("drain_timeout", 32'(exp_q.size()), 32'd0);
                exp_q.delete();
            end
        end
    endtask

    // Monitor: latency on the rising edge of out_valid, data on each handshake.
    bit prev_v = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 0;
        end else begin
            if (out_valid && exp_q.size() == 0) begin
                chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else if (out_valid) begin
                if (!prev_v)
                    chk("latency", 32'(cyc - exp_q[0].acc + 1), 32'(exp_q[0].lat));
                if (out_ready) begin
                    chk("out_data", out_data, exp_q[0].val);
                    void'(exp_q.pop_front());
                end
            end
            prev_v = out_valid && !out_ready;
        end
    end

    always @(negedge clk) begin
        if (rand_ready) out_ready = ($urandom_range(3, 0) != 0);
    end

    initial begin
        logic [31:0] held;
        logic [31:0] v;
        int unsigned sh;
        int unsigned guard;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send(32'h0001_0000, 32'h3F80_0000, 18);
        send(32'hFFFF_0000, 32'hBF80_0000, 18);
        send(32'h8000_0000, 32'hC700_0000, 3);
        send(32'h0000_0000, 32'h0000_0000, 2);
        send(32'h7FFF_FFFF, 32'h4700_0000, 4);
        send(32'h0100_0001, 32'h4380_0000, 10);
        send(32'h0100_0003, 32'h4380_0002, 10);
        send(32'h0000_0001, 32'h3780_0000, 34);
        drain();

        rand_ready = 1;
        for (int i = 0; i < 150; i++) begin
            sh = $urandom_range(31, 0);
            v  = $urandom >> sh;
            if (i % 7 == 3) v = (v & 32'hFFFF_FF00) | 32'h0000_0080;
            if ($urandom_range(1, 0) == 1) v = -v;
            send_rand(v);
        end
        drain();
        rand_ready = 0;
        out_ready  = 1'b1;

        // Backpressure with an ignored extra request.
        @(negedge clk);
        out_ready = 1'b0;
        send_rand(32'h0003_2468);
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("bp_valid_seen", {31'd0, out_valid}, 32'd1);
        held = out_data;
        chk("bp_data_first", held, ref_fp(32'h0003_2468));
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 4);
            in_data  = 32'h1234_5678;
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_data", out_data, held);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (40) @(negedge clk);
        chk("bp_idle_after", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of normalization aborts the conversion.
        send_rand(32'h0000_0001);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_reset_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("post_reset_quiet", 32'(exp_q.size()), 32'd0);

        send(32'hFFFF_0000, 32'hBF80_0000, 18);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
